// File: rtl/gtx_rate_ctrl.sv
// GTX TX rate controller: applies the requested divider rate, pulses the GTX reset,
// waits for a settled PLL lock, runs the downstream clock test and reports readiness.
module gtx_rate_ctrl #(
  parameter int RST_CYCLES   = 8,
  parameter int SETTLE       = 4,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int DONE_TIMEOUT = 4096,
  parameter int FAULT_WAIT   = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RATE_REQ,
  input  logic       PLLLKDET,
  input  logic       GTXTEST_DONE,
  output logic       TX_RATE,
  output logic       GTX_RST,
  output logic       ENA,
  output logic       TX_READY,
  output logic [3:0] ERR_CNT,
  output logic [2:0] STATE
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int DW = $clog2(DONE_TIMEOUT + 1);
  localparam int FW = $clog2(FAULT_WAIT + 1);

  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_TIMEOUT - 1);
  localparam logic [DW-1:0] DONE_LAST   = DW'(DONE_TIMEOUT - 1);
  localparam logic [FW-1:0] FAULT_LAST  = FW'(FAULT_WAIT - 1);

  typedef enum logic [2:0] {
    ST_APPLY     = 3'd0,
    ST_PLLRST    = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_TEST      = 3'd3,
    ST_READY     = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            lock;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [LW-1:0]   lock_to_q, lock_to_d;
  logic [DW-1:0]   done_to_q, done_to_d;
  logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
  logic            tx_rate_q, tx_rate_d;
  logic            gtx_rst_q, gtx_rst_d;
  logic            ena_q, ena_d;
  logic            tx_ready_q, tx_ready_d;
  logic [3:0]      err_cnt_q, err_cnt_d;

  assign lock = sync_q[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_APPLY;
      sync_q     <= '0;
      rst_cnt_q  <= '0;
      settle_q   <= '0;
      lock_to_q  <= '0;
      done_to_q  <= '0;
      flt_cnt_q  <= '0;
      tx_rate_q  <= 1'b1;
      gtx_rst_q  <= 1'b1;
      ena_q      <= 1'b0;
      tx_ready_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], PLLLKDET};
      rst_cnt_q  <= rst_cnt_d;
      settle_q   <= settle_d;
      lock_to_q  <= lock_to_d;
      done_to_q  <= done_to_d;
      flt_cnt_q  <= flt_cnt_d;
      tx_rate_q  <= tx_rate_d;
      gtx_rst_q  <= gtx_rst_d;
      ena_q      <= ena_d;
      tx_ready_q <= tx_ready_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Each counter only runs in its own state and reads zero on entry.
  always_comb begin
    state_d   = state_q;
    tx_rate_d = tx_rate_q;
    rst_cnt_d = '0;
    settle_d  = '0;
    lock_to_d = '0;
    done_to_d = '0;
    flt_cnt_d = '0;
    case (state_q)
      ST_APPLY: begin
        tx_rate_d = RATE_REQ;
        state_d   = ST_PLLRST;
      end
      ST_PLLRST: begin
        if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (lock && settle_q == SETTLE_LAST) state_d = ST_TEST;
        else if (lock_to_q == LOCK_LAST) state_d = ST_FAULT;
        else begin
          settle_d  = lock ? settle_q + 1'b1 : '0;
          lock_to_d = lock_to_q + 1'b1;
        end
      end
      // Losing lock outranks a completion flag seen in the same cycle.
      ST_TEST: begin
        if (!lock) state_d = ST_PLLRST;
        else if (GTXTEST_DONE) state_d = ST_READY;
        else if (done_to_q == DONE_LAST) state_d = ST_FAULT;
        else done_to_d = done_to_q + 1'b1;
      end
      ST_READY: begin
        if (RATE_REQ != tx_rate_q) state_d = ST_APPLY;
        else if (!lock) state_d = ST_PLLRST;
      end
      ST_FAULT: begin
        if (flt_cnt_q == FAULT_LAST) state_d = ST_APPLY;
        else flt_cnt_d = flt_cnt_q + 1'b1;
      end
      default: state_d = ST_APPLY;
    endcase

    // Outputs are registered from the next state so they line up with STATE.
    gtx_rst_d  = state_d inside {ST_APPLY, ST_PLLRST, ST_FAULT};
    ena_d      = state_d inside {ST_TEST, ST_READY};
    tx_ready_d = (state_d == ST_READY);
    err_cnt_d  = err_cnt_q;
    if (state_d == ST_FAULT && state_q != ST_FAULT && err_cnt_q != 4'hF)
      err_cnt_d = err_cnt_q + 1'b1;
  end

  assign TX_RATE  = tx_rate_q;
  assign GTX_RST  = gtx_rst_q;
  assign ENA      = ena_q;
  assign TX_READY = tx_ready_q;
  assign ERR_CNT  = err_cnt_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_gtx_rate_ctrl.sv
// Randomised bench for gtx_rate_ctrl: a behavioural model tracks state and time-in-state,
// a negedge process compares every output each cycle, and directed phases pin key timings.
module tb_gtx_rate_ctrl;
  localparam int RST_CYCLES = 8;
  localparam int SETTLE     = 4;
  localparam int LOCK_TO    = 40;
  localparam int DONE_TO    = 30;
  localparam int FAULT_WAIT = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RATE_REQ = 1'b1;
  logic       PLLLKDET = 1'b0;
  logic       GTXTEST_DONE = 1'b0;
  logic       TX_RATE, GTX_RST, ENA, TX_READY;
  logic [3:0] ERR_CNT;
  logic [2:0] STATE;

  int n_vec = 0;
  int n_bad = 0;
  int done_delay = 10;

  always #5 CLK = ~CLK;

  gtx_rate_ctrl #(
    .RST_CYCLES(RST_CYCLES), .SETTLE(SETTLE), .LOCK_TIMEOUT(LOCK_TO),
    .DONE_TIMEOUT(DONE_TO), .FAULT_WAIT(FAULT_WAIT)
  ) dut (
    .CLK(CLK), .RST(RST), .RATE_REQ(RATE_REQ), .PLLLKDET(PLLLKDET),
    .GTXTEST_DONE(GTXTEST_DONE), .TX_RATE(TX_RATE), .GTX_RST(GTX_RST),
    .ENA(ENA), .TX_READY(TX_READY), .ERR_CNT(ERR_CNT), .STATE(STATE)
  );

  // Model: phase number, cycles spent in it, consecutive-lock run, last two lock samples.
  int     m_state = 0;
  int     m_time = 0;
  int     m_settle = 0;
  int     m_err = 0;
  bit     m_rate = 1'b1;
  bit [1:0] m_hist = 2'b00;

  function automatic void m_go(input int s);
    m_state = s;
    m_time = 0;
    m_settle = 0;
    if (s == 5 && m_err < 15) m_err++;
  endfunction

  function automatic void m_reset();
    m_state = 0; m_time = 0; m_settle = 0; m_err = 0; m_rate = 1'b1; m_hist = 2'b00;
  endfunction

  function automatic void m_step();
    bit lock;
    lock = m_hist[1];
    case (m_state)
      0: begin m_rate = RATE_REQ; m_go(1); end
      1: begin m_time++; if (m_time == RST_CYCLES) m_go(2); end
      2: begin
        m_time++;
        m_settle = lock ? m_settle + 1 : 0;
        if (m_settle == SETTLE) m_go(3);
        else if (m_time == LOCK_TO) m_go(5);
      end
      3: begin
        m_time++;
        if (!lock) m_go(1);
        else if (GTXTEST_DONE) m_go(4);
        else if (m_time == DONE_TO) m_go(5);
      end
      4: begin
        if (RATE_REQ != m_rate) m_go(0);
        else if (!lock) m_go(1);
      end
      5: begin m_time++; if (m_time == FAULT_WAIT) m_go(0); end
      default: m_go(0);
    endcase
    m_hist = {m_hist[0], PLLLKDET};
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m_reset();
    else m_step();
  end

  always @(negedge CLK) begin
    logic [2:0] e_state;
    logic       e_gtx, e_ena, e_rdy;
    logic [3:0] e_err;
    e_state = 3'(m_state);
    e_gtx   = (m_state == 0 || m_state == 1 || m_state == 5);
    e_ena   = (m_state == 3 || m_state == 4);
    e_rdy   = (m_state == 4);
    e_err   = 4'(m_err);
    n_vec++;
    if ({STATE, TX_RATE, GTX_RST, ENA, TX_READY, ERR_CNT} !==
        {e_state, m_rate, e_gtx, e_ena, e_rdy, e_err}) begin
      n_bad++;
      $display("FAIL cycle t=%0t actual st=%0d rate=%b rst=%b ena=%b rdy=%b err=%0d required st=%0d rate=%b rst=%b ena=%b rdy=%b err=%0d",
               $time, STATE, TX_RATE, GTX_RST, ENA, TX_READY, ERR_CNT,
               e_state, m_rate, e_gtx, e_ena, e_rdy, e_err);
    end
  end

  function automatic void pin(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
    GTXTEST_DONE = (done_delay >= 0 && m_state == 3 && m_time >= done_delay);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k;
    k = 0;
    while (STATE !== 3'(s) && k < budget) begin tick(); k++; end
    pin(name, int'(STATE === 3'(s)), 1);
  endtask

  task automatic count_gtx(output int cnt);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (GTX_RST === 1'b1) cnt++;
      else break;
    end
  endtask

  task automatic count_in(input int s, output int cnt);
    cnt = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (STATE === 3'(s)) cnt++;
      else break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    int seen;
    repeat (3) tick();
    pin("rst_state", int'(STATE), 0);
    pin("rst_gtx", int'(GTX_RST), 1);
    pin("rst_rate", int'(TX_RATE), 1);
    pin("rst_ena", int'(ENA), 0);
    pin("rst_err", int'(ERR_CNT), 0);

    // Bring-up at full rate with steady lock, done 10 cycles after ENA.
    PLLLKDET = 1'b1; RATE_REQ = 1'b1; done_delay = 10;
    @(posedge CLK); #1 RST = 1'b0;
    count_gtx(cnt);
    pin("gtx_rst_len", cnt, 9);
    wait_state(3, 20, "reach_test");
    pin("ena_in_test", int'(ENA), 1);
    wait_state(4, 40, "reach_ready");
    pin("ready_flag", int'(TX_READY), 1);
    pin("ready_err", int'(ERR_CNT), 0);

    // Rate change to half.
    RATE_REQ = 1'b0;
    tick();
    pin("rdy_drop", int'(TX_READY), 0);
    pin("apply_state", int'(STATE), 0);
    count_gtx(cnt);
    pin("gtx_rst_len2", cnt + 1, 9);
    wait_state(4, 60, "ready_half");
    pin("half_rate", int'(TX_RATE), 0);

    // Short lock loss from READY.
    PLLLKDET = 1'b0;
    seen = 0;
    repeat (3) begin tick(); if (STATE === 3'd1) seen = 1; end
    PLLLKDET = 1'b1;
    pin("pllrst_seen", seen, 1);
    pin("rate_kept", int'(TX_RATE), 0);
    wait_state(4, 60, "ready_relock");

    // Lock held low: repeated timeouts, counter saturates.
    PLLLKDET = 1'b0;
    wait_state(5, 100, "fault_lock");
    pin("err_one", int'(ERR_CNT), 1);
    pin("fault_gtx", int'(GTX_RST), 1);
    for (int k = 0; k < 16; k++) begin
      wait_state(0, 40, "fault_retry");
      wait_state(5, 100, "fault_again");
    end
    count_in(5, cnt);
    pin("fault_len", cnt, FAULT_WAIT);
    pin("err_sat", int'(ERR_CNT), 15);

    // Done never arrives: TEST timeout, then done on the timeout cycle.
    PLLLKDET = 1'b1; done_delay = -1;
    wait_state(3, 100, "test_to_entry");
    count_in(3, cnt);
    pin("test_len", cnt, DONE_TO);
    pin("test_to_fault", int'(STATE), 5);
    done_delay = DONE_TO - 1;
    wait_state(3, 100, "tie_entry");
    count_in(3, cnt);
    pin("tie_len", cnt, DONE_TO);
    pin("tie_ready", int'(STATE), 4);

    // Asynchronous reset in the middle of TEST.
    RATE_REQ = 1'b0; done_delay = -1;
    PLLLKDET = 1'b1;
    tick();
    RATE_REQ = 1'b1;
    wait_state(3, 100, "test_for_rst");
    repeat (3) tick();
    #2 RST = 1'b1;
    #1;
    pin("arst_ena", int'(ENA), 0);
    pin("arst_gtx", int'(GTX_RST), 1);
    pin("arst_rate", int'(TX_RATE), 1);
    pin("arst_err", int'(ERR_CNT), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    done_delay = 10;
    count_gtx(cnt);
    pin("gtx_rst_len3", cnt, 9);
    wait_state(4, 60, "ready_after_rst");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (m_state != 3) done_delay = int'($urandom_range(0, DONE_TO + 3));
      if ($urandom_range(0, 99) < 3) RATE_REQ = ~RATE_REQ;
      if (PLLLKDET && $urandom_range(0, 99) < 2) PLLLKDET = 1'b0;
      else if (!PLLLKDET && $urandom_range(0, 99) < 25) PLLLKDET = 1'b1;
      if ($urandom_range(0, 499) == 0) begin
        #2 RST = 1'b1;
        tick();
        tick();
        #1 RST = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gtx_rate_ctrl.md
GTX_RATE_CTRL -- requirements
Module: gtx_rate_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 8: cycles GTX_RST is held high per reset pulse.
REQ-002 Parameter SETTLE, default 4: consecutive synchronized-lock cycles required before test start.
REQ-003 Parameter LOCK_TIMEOUT, default 4096: maximum cycles in WAIT_LOCK.
REQ-004 Parameter DONE_TIMEOUT, default 4096: maximum cycles in TEST.
REQ-005 Parameter FAULT_WAIT, default 16: cycles spent in FAULT before automatic retry.
REQ-006 CLK  input  1  single system clock; all logic on rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 RATE_REQ  input  1  requested TX clock-divider rate (1 = full, 0 = half).
REQ-009 PLLLKDET  input  1  GTX PLL lock, asynchronous to CLK.
REQ-010 GTXTEST_DONE  input  1  completion flag from downstream clk_div_reset, CLK domain.
REQ-011 TX_RATE  output  1  rate applied to GTX and clk_div_reset.
REQ-012 GTX_RST  output  1  GTX TX reset request.
REQ-013 ENA  output  1  enable to clk_div_reset.
REQ-014 TX_READY  output  1  link clocking valid at TX_RATE.
REQ-015 ERR_CNT  output  4  saturating fault counter.
REQ-016 STATE  output  3  current state encoding, debug.

Function
REQ-017 PLLLKDET SHALL pass a 2-flop synchronizer; "lock" below means synchronizer output (2-cycle latency).
REQ-018 States: APPLY=0, PLLRST=1, WAIT_LOCK=2, TEST=3, READY=4, FAULT=5; codes 6/7 SHALL go to APPLY next cycle.
REQ-019 APPLY: one cycle; TX_RATE <= RATE_REQ; GTX_RST=1, ENA=0, TX_READY=0; next PLLRST.
REQ-020 PLLRST: GTX_RST=1 for exactly RST_CYCLES cycles, TX_RATE frozen; next WAIT_LOCK.
REQ-021 WAIT_LOCK: GTX_RST=0, ENA=0; settle counter increments while lock=1, clears to 0 when lock=0; on reaching SETTLE go TEST.
REQ-022 WAIT_LOCK timeout counter SHALL start at 0 on entry; reaching LOCK_TIMEOUT without settle SHALL go FAULT; settle and timeout on same cycle resolves to TEST.
REQ-023 TEST: ENA=1; GTXTEST_DONE=1 goes READY; DONE_TIMEOUT cycles elapsed goes FAULT; DONE wins on tie.
REQ-024 TEST: lock=0 SHALL abort to PLLRST, ENA=0 the next cycle.
REQ-025 READY: ENA=1, TX_READY=1, GTX_RST=0.
REQ-026 READY: RATE_REQ != TX_RATE goes APPLY; lock=0 goes PLLRST (TX_RATE unchanged); both same cycle: APPLY.
REQ-027 TX_READY and ENA SHALL drop in the cycle after the leaving event; never high outside READY (ENA also high in TEST).
REQ-028 FAULT: GTX_RST=1, ENA=0; ERR_CNT increments once on entry, saturates at 15; after FAULT_WAIT cycles go APPLY (re-samples RATE_REQ).
REQ-029 RATE_REQ changes outside READY SHALL be ignored until READY, or taken at next APPLY.
REQ-030 All outputs SHALL be registered; counters sized ceil(log2(param+1)), no wrap.

Reset
REQ-031 RST=1 SHALL immediately force: STATE=APPLY, TX_RATE=1, GTX_RST=1, ENA=0, TX_READY=0, ERR_CNT=0, counters and synchronizer cleared.
REQ-032 RST assertion mid-sequence SHALL abort with no partial outputs; after release the first edge executes APPLY.
REQ-033 ERR_CNT SHALL clear only on RST.

Verification
REQ-034 RST release, RATE_REQ=1, PLLLKDET=1 steady, DONE 10 cycles after ENA -> GTX_RST high 9 cycles (APPLY+8), ENA rises after lock settle, TX_READY=1, ERR_CNT=0.
REQ-035 In READY, RATE_REQ 1->0 -> TX_READY=0 next cycle, TX_RATE=0, GTX_RST 9 cycles, ENA re-asserts, READY again with TX_RATE=0.
REQ-036 In READY, PLLLKDET low 3 cycles -> PLLRST entered (STATE=1), TX_RATE unchanged, recovers to READY when lock returns.
REQ-037 PLLLKDET held 0 -> FAULT after 4096 WAIT_LOCK cycles, ERR_CNT=1, GTX_RST=1, retry at APPLY after 16 cycles; 16 repeats -> ERR_CNT=15, holds.
REQ-038 GTXTEST_DONE held 0 -> FAULT after 4096 TEST cycles; DONE and timeout same cycle -> READY.
REQ-039 RST asserted during TEST -> ENA=0, GTX_RST=1, TX_RATE=1 asynchronously; full sequence restarts on release.
